inst_fetch: RTL

- PC generation and IF/ID pipeline-register stage, directly upstream of the instruction ROM.
- Drives the ROM byte address from a registered PC and captures the ROM's combinational, byte-flipped instruction word into an IF/ID register for the decoder.
- Handles sequential fetch, branch/jump redirect (including redirect arriving under stall), stall, flush and halt/resume.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/inst_fetch.sv | 128 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants for the instruction fetch stage
//   FSM state encoding, default reset PC, NOP word and the word-align helper.
package inst_fetch_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0000;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC generation and IF/ID pipeline register
//   clock/reset      : rising-edge clock, synchronous active-low reset
//   stall/flush      : hold the stage / kill the IF/ID contents
//   redirect_*       : branch/jump target, remembered if it arrives under stall
//   halt_req/resume  : enter and leave the HALT state
//   rom_addr/rom_data: byte address to the instruction ROM and its word
//   if_*             : IF/ID register towards the decoder
//   halted           : stage is in HALT
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          ADDR_WIDTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_misalign,
  output logic        halted
);

  // The ROM word index is rom_addr[ADDR_WIDTH+1:2]; the PC itself stays full
  // width and wraps only through that truncation.
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 30) begin : g_bad_addr_width
    $error("inst_fetch: ADDR_WIDTH out of range");
  end

  logic [1:0]  state;
  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic        mis_flag;
  logic        if_mis_q;

  logic [31:0] pc_plus4;
  logic        redir_taken;
  logic [31:0] redir_target;
  logic [31:0] next_pc;
  logic        next_mis;

  // A live redirect wins over a remembered one; either way the pending
  // slot is consumed when the stage advances.
  always_comb begin
    pc_plus4     = pc + 32'd4;
    redir_taken  = redirect_valid | pend_valid;
    redir_target = redirect_valid ? redirect_target : pend_target;
    next_pc      = redir_taken ? word_align(redir_target) : pc_plus4;
    next_mis     = redir_taken && (redir_target[1:0] != 2'b00);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
      mis_flag    <= 1'b0;
      if_valid    <= 1'b0;
      if_inst     <= INST_NOP;
      if_pc       <= 32'h0;
      if_pc_plus4 <= 32'h0;
      if_mis_q    <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          // One idle cycle so the ROM sees RESET_PC before the first capture.
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (stall) begin
            // Remember the newest redirect seen while stalled.
            if (redirect_valid) begin
              pend_valid  <= 1'b1;
              pend_target <= redirect_target;
            end
          end else begin
            // The word at pc is always captured, so the instruction on the
            // redirecting edge survives as the delay slot.
            if_valid    <= 1'b1;
            if_inst     <= rom_data;
            if_pc       <= pc;
            if_pc_plus4 <= pc_plus4;
            if_mis_q    <= mis_flag;
            pc          <= next_pc;
            mis_flag    <= next_mis;
            if (redir_taken) begin
              pend_valid <= 1'b0;
            end
            if (halt_req) begin
              state <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          if_valid <= 1'b0;
          if (resume) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_BOOT;
        end
      endcase

      // Flush only kills IF/ID; the PC path above is unaffected.
      if (flush) begin
        if_valid <= 1'b0;
        if_inst  <= INST_NOP;
      end
    end
  end

  assign rom_addr    = pc;
  assign halted      = (state == ST_HALT);
  assign if_misalign = if_mis_q & if_valid;

endmodule
